// File: rtl/vram_write_arbiter_pkg.sv
// Shared constants and types for the text-VRAM port-A write arbiter.
// The 60x17 grid occupies addresses 0..1019 of the 1024-entry VRAM.
package vram_write_arbiter_pkg;

  localparam int unsigned COLS       = 60;
  localparam int unsigned ROWS       = 17;
  localparam int unsigned ADDR_W     = 10;
  localparam int unsigned VRAM_DEPTH = 1024;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    RUN,
    DONE
  } fill_state_t;

  typedef struct packed {
    logic [5:0] col;
    logic [4:0] row;
    logic [6:0] w;
    logic [4:0] h;
    logic [7:0] ch;
  } fill_req_t;

endpackage

// File: rtl/vram_write_arbiter_if.sv
// Bus bundle between the CPU/fill requester, the arbiter and VRAM port A.
// The master drives CPU writes and fill requests; the slave is the arbiter.
interface vram_write_arbiter_if;
  import vram_write_arbiter_pkg::*;

  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_din;
  logic              fill_start;
  logic [5:0]        fill_col;
  logic [4:0]        fill_row;
  logic [6:0]        fill_w;
  logic [4:0]        fill_h;
  logic [7:0]        fill_char;
  logic              fill_busy;
  logic              fill_done;
  logic [ADDR_W-1:0] v_ada;
  logic              v_cea;
  logic [7:0]        v_din;

  modport master (
    output cpu_we, cpu_addr, cpu_din,
    output fill_start, fill_col, fill_row, fill_w, fill_h, fill_char,
    input  fill_busy, fill_done, v_ada, v_cea, v_din
  );

  modport slave (
    input  cpu_we, cpu_addr, cpu_din,
    input  fill_start, fill_col, fill_row, fill_w, fill_h, fill_char,
    output fill_busy, fill_done, v_ada, v_cea, v_din
  );

endinterface

// File: rtl/vram_write_arbiter_fill_addr_gen.sv
// Rectangle clipping and row-major address walk for the fill engine.
// Clip result is combinational from the captured request; counters load on 'load'.
module vram_write_arbiter_fill_addr_gen
  import vram_write_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  input  logic [5:0]        col,
  input  logic [4:0]        row,
  input  logic [6:0]        w,
  input  logic [4:0]        h,
  output logic              empty,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic              col_ok, row_ok;
  logic [6:0]        col_room, ew;
  logic [4:0]        row_room, eh;
  logic [ADDR_W-1:0] base;

  logic [6:0]        ew_q, x_q;
  logic [4:0]        eh_q, y_q;
  logic [ADDR_W-1:0] row_base_q;
  logic              x_last;

  always_comb begin
    col_ok   = {1'b0, col} < 7'(COLS);
    row_ok   = row < 5'(ROWS);
    col_room = 7'(COLS) - {1'b0, col};
    row_room = 5'(ROWS) - row;
    ew       = (w < col_room) ? w : col_room;
    eh       = (h < row_room) ? h : row_room;
    empty    = !col_ok || !row_ok || (ew == '0) || (eh == '0);
    // row*60 as row*64 - row*4; modulo wrap is harmless since only row<17 is used
    base     = ADDR_W'({row, 6'b0}) - ADDR_W'({row, 2'b0}) + ADDR_W'(col);
  end

  assign addr   = row_base_q + ADDR_W'(x_q);
  assign x_last = (x_q == ew_q - 7'd1);
  assign last   = x_last && (y_q == eh_q - 5'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      ew_q       <= '0;
      eh_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      row_base_q <= '0;
    end else if (load) begin
      ew_q       <= ew;
      eh_q       <= eh;
      x_q        <= '0;
      y_q        <= '0;
      row_base_q <= base;
    end else if (advance) begin
      if (x_last) begin
        x_q        <= '0;
        y_q        <= y_q + 5'd1;
        row_base_q <= row_base_q + ADDR_W'(COLS);
      end else begin
        x_q <= x_q + 7'd1;
      end
    end
  end

endmodule

// File: rtl/vram_write_arbiter.sv
// VRAM port-A owner: fixed-priority CPU pass-through plus a rectangle-fill engine
// that writes one character on every cycle the CPU leaves free.
module vram_write_arbiter
  import vram_write_arbiter_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  vram_write_arbiter_if.slave bus
);

  fill_state_t       state_q;
  fill_req_t         req_q;
  logic              v_cea_q, busy_q, done_q;
  logic [ADDR_W-1:0] v_ada_q;
  logic [7:0]        v_din_q;

  logic              gen_load, gen_advance, gen_empty, gen_last;
  logic [ADDR_W-1:0] gen_addr;

  // Engine only moves on cycles the CPU does not claim, so a deferred write keeps its address.
  assign gen_load    = (state_q == SETUP);
  assign gen_advance = (state_q == RUN) && !bus.cpu_we;

  vram_write_arbiter_fill_addr_gen u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (gen_load),
    .advance (gen_advance),
    .col     (req_q.col),
    .row     (req_q.row),
    .w       (req_q.w),
    .h       (req_q.h),
    .empty   (gen_empty),
    .addr    (gen_addr),
    .last    (gen_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= '0;
      v_cea_q <= 1'b0;
      v_ada_q <= '0;
      v_din_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      v_cea_q <= 1'b0;
      done_q  <= 1'b0;

      if (bus.cpu_we) begin
        v_cea_q <= 1'b1;
        v_ada_q <= bus.cpu_addr;
        v_din_q <= bus.cpu_din;
      end else if (state_q == RUN) begin
        v_cea_q <= 1'b1;
        v_ada_q <= gen_addr;
        v_din_q <= req_q.ch;
      end

      case (state_q)
        IDLE: begin
          if (bus.fill_start) begin
            req_q   <= '{col: bus.fill_col, row: bus.fill_row, w: bus.fill_w,
                         h: bus.fill_h, ch: bus.fill_char};
            state_q <= SETUP;
            busy_q  <= 1'b1;
          end
        end
        SETUP: begin
          if (gen_empty) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (gen_advance && gen_last) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.v_cea     = v_cea_q;
  assign bus.v_ada     = v_ada_q;
  assign bus.v_din     = v_din_q;
  assign bus.fill_busy = busy_q;
  assign bus.fill_done = done_q;

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Self-checking bench for vram_write_arbiter: table-driven fills, hand-written
// corner sequences and random traffic against a queue-based reference model.
module tb_vram_write_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vram_write_arbiter_if bus ();

  vram_write_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  // Reference model: the clipped rectangle expands to a queue of addresses that
  // drains one entry per CPU-free cycle once the setup cycle has passed.
  int         m_stage;  // 0 idle, 1 setup, 2 writing, 3 done pending
  int         m_q[$];
  logic [7:0] m_char;
  logic       e_cea, e_busy, e_done;
  logic [9:0] e_ada;
  logic [7:0] e_din;
  logic       cpu_at_edge, rst_at_edge;

  int eng_log[$];
  int done_log[$];
  int busy_cnt;

  typedef struct {
    int col, row, w, h, ch;
    int n_wr, first_a, last_a;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
  endtask

  function automatic void build_rect(input int col, input int row, input int w, input int h);
    int ew, eh;
    m_q.delete();
    if (col >= 60 || row >= 17) return;
    ew = (w < 60 - col) ? w : 60 - col;
    eh = (h < 17 - row) ? h : 17 - row;
    for (int y = 0; y < eh; y++)
      for (int x = 0; x < ew; x++)
        m_q.push_back((row + y) * 60 + col + x);
  endfunction

  task automatic model_step();
    rst_at_edge = rst;
    cpu_at_edge = bus.cpu_we;
    if (rst) begin
      m_stage = 0;
      m_q.delete();
      e_cea = 1'b0; e_ada = '0; e_din = '0; e_busy = 1'b0; e_done = 1'b0;
      return;
    end
    e_done = (m_stage == 3);
    if (bus.cpu_we) begin
      e_cea = 1'b1; e_ada = bus.cpu_addr; e_din = bus.cpu_din;
    end else if (m_stage == 2) begin
      e_cea = 1'b1; e_ada = 10'(m_q.pop_front()); e_din = m_char;
    end else begin
      e_cea = 1'b0;
    end
    case (m_stage)
      0: if (bus.fill_start) begin
        build_rect(int'(bus.fill_col), int'(bus.fill_row), int'(bus.fill_w), int'(bus.fill_h));
        m_char  = bus.fill_char;
        m_stage = 1;
      end
      1: m_stage = (m_q.size() != 0) ? 2 : 3;
      2: if (m_q.size() == 0) m_stage = 3;
      3: m_stage = 0;
      default: m_stage = 0;
    endcase
    e_busy = (m_stage == 1) || (m_stage == 2);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    chk("v_cea", 32'(bus.v_cea), 32'(e_cea));
    chk("v_ada", 32'(bus.v_ada), 32'(e_ada));
    chk("v_din", 32'(bus.v_din), 32'(e_din));
    chk("fill_busy", 32'(bus.fill_busy), 32'(e_busy));
    chk("fill_done", 32'(bus.fill_done), 32'(e_done));
    if (bus.v_cea && !cpu_at_edge && !rst_at_edge) eng_log.push_back(int'(bus.v_ada));
    if (bus.fill_done) done_log.push_back(cyc);
    if (bus.fill_busy) busy_cnt++;
  endtask

  task automatic drive_fill(input int col, input int row, input int w, input int h, input int ch);
    bus.fill_start = 1'b1;
    bus.fill_col   = 6'(col);
    bus.fill_row   = 5'(row);
    bus.fill_w     = 7'(w);
    bus.fill_h     = 5'(h);
    bus.fill_char  = 8'(ch);
  endtask

  task automatic clear_logs();
    eng_log.delete();
    done_log.delete();
    busy_cnt = 0;
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget && done_log.size() == 0; k++) tick();
  endtask

  int start_cyc;
  int exp_c[8];

  initial begin
    vecs[0] = '{0,  0,  60,  17, 8'h20, 1020, 0,    1019};
    vecs[1] = '{58, 16, 5,   3,  8'h2E, 2,    1018, 1019};
    vecs[2] = '{60, 0,  5,   5,  8'h11, 0,    0,    0};
    vecs[3] = '{0,  0,  0,   5,  8'h12, 0,    0,    0};
    vecs[4] = '{10, 2,  4,   2,  8'h41, 8,    130,  193};
    vecs[5] = '{0,  16, 100, 5,  8'h5F, 60,   960,  1019};
    vecs[6] = '{0,  17, 5,   5,  8'h13, 0,    0,    0};
    vecs[7] = '{59, 0,  1,   1,  8'h7E, 1,    59,   59};
    exp_c   = '{130, 131, 132, 133, 190, 191, 192, 193};

    // Reset held with a CPU strobe active: outputs must stay cleared.
    rst = 1'b1;
    bus.cpu_we = 1'b1; bus.cpu_addr = 10'h155; bus.cpu_din = 8'h77;
    bus.fill_start = 1'b0; bus.fill_col = '0; bus.fill_row = '0;
    bus.fill_w = '0; bus.fill_h = '0; bus.fill_char = '0;
    repeat (3) begin
      tick();
      chk("reset_cea", 32'(bus.v_cea), 32'd0);
      chk("reset_busy", 32'(bus.fill_busy), 32'd0);
    end
    rst = 1'b0;
    tick();
    chk("first_cpu_cea", 32'(bus.v_cea), 32'd1);
    chk("first_cpu_ada", 32'(bus.v_ada), 32'h155);

    // Single CPU write, then the top-of-range address.
    bus.cpu_addr = 10'h2A5; bus.cpu_din = 8'h41;
    tick();
    chk("cpu_ada", 32'(bus.v_ada), 32'h2A5);
    chk("cpu_din", 32'(bus.v_din), 32'h41);
    bus.cpu_we = 1'b0;
    tick();
    chk("cpu_cea_low", 32'(bus.v_cea), 32'd0);
    bus.cpu_we = 1'b1; bus.cpu_addr = 10'd1023; bus.cpu_din = 8'hAB;
    tick();
    chk("cpu_ada_1023", 32'(bus.v_ada), 32'd1023);
    bus.cpu_we = 1'b0;
    tick();

    // Uncontested fills from the table.
    for (int i = 0; i < $size(vecs); i++) begin
      clear_logs();
      drive_fill(vecs[i].col, vecs[i].row, vecs[i].w, vecs[i].h, vecs[i].ch);
      start_cyc = cyc + 1;
      tick();
      bus.fill_start = 1'b0;
      wait_done(1100);
      repeat (3) tick();
      chk("vec_writes", 32'(eng_log.size()), 32'(vecs[i].n_wr));
      if (vecs[i].n_wr > 0 && eng_log.size() > 0) begin
        chk("vec_first_addr", 32'(eng_log[0]), 32'(vecs[i].first_a));
        chk("vec_last_addr", 32'(eng_log[eng_log.size()-1]), 32'(vecs[i].last_a));
      end
      chk("vec_done_pulses", 32'(done_log.size()), 32'd1);
      chk("vec_done_at", (done_log.size() > 0) ? 32'(done_log[0] - start_cyc) : 32'hFFFF_FFFF,
          32'(vecs[i].n_wr + 2));
      chk("vec_busy_cycles", 32'(busy_cnt), 32'(vecs[i].n_wr + 1));
    end

    // Contention: CPU strobes every other cycle while a 4x2 fill runs.
    clear_logs();
    drive_fill(10, 2, 4, 2, 8'h33);
    start_cyc = cyc + 1;
    tick();
    bus.fill_start = 1'b0;
    for (int k = 0; k < 80 && done_log.size() == 0; k++) begin
      bus.cpu_we   = (k % 2 == 0);
      bus.cpu_addr = 10'(900 + k);
      bus.cpu_din  = 8'(k);
      tick();
    end
    bus.cpu_we = 1'b0;
    tick();
    chk("cont_writes", 32'(eng_log.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      if (i < eng_log.size()) chk("cont_order", 32'(eng_log[i]), 32'(exp_c[i]));
    chk("cont_done_at", (done_log.size() > 0) ? 32'(done_log[0] - start_cyc) : 32'hFFFF_FFFF,
        32'd17);

    // A second start while running is dropped.
    clear_logs();
    drive_fill(10, 2, 4, 2, 8'h44);
    tick();
    bus.fill_start = 1'b0;
    repeat (3) tick();
    drive_fill(0, 0, 60, 17, 8'h55);
    tick();
    bus.fill_start = 1'b0;
    wait_done(100);
    repeat (5) tick();
    chk("ignored_start_writes", 32'(eng_log.size()), 32'd8);
    chk("ignored_start_done", 32'(done_log.size()), 32'd1);

    // Reset on the 5th write of a full clear aborts silently.
    clear_logs();
    drive_fill(0, 0, 60, 17, 8'h20);
    tick();
    bus.fill_start = 1'b0;
    for (int k = 0; k < 50 && eng_log.size() < 5; k++) tick();
    rst = 1'b1;
    tick();
    chk("abort_cea", 32'(bus.v_cea), 32'd0);
    rst = 1'b0;
    repeat (30) tick();
    chk("abort_writes", 32'(eng_log.size()), 32'd5);
    chk("abort_no_done", 32'(done_log.size()), 32'd0);
    clear_logs();
    drive_fill(10, 2, 4, 2, 8'h66);
    tick();
    bus.fill_start = 1'b0;
    wait_done(100);
    tick();
    chk("post_abort_writes", 32'(eng_log.size()), 32'd8);
    chk("post_abort_done", 32'(done_log.size()), 32'd1);

    // Random traffic, checked cycle by cycle against the model.
    for (int t = 0; t < 3000; t++) begin
      rst            = ($urandom_range(0, 599) == 0);
      bus.cpu_we     = ($urandom_range(0, 2) == 0);
      bus.cpu_addr   = 10'($urandom);
      bus.cpu_din    = 8'($urandom);
      bus.fill_start = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 3) == 0) begin
        bus.fill_col = 6'($urandom);
        bus.fill_row = 5'($urandom);
        bus.fill_w   = 7'($urandom);
        bus.fill_h   = 5'($urandom);
      end else begin
        bus.fill_col = 6'($urandom_range(0, 63));
        bus.fill_row = 5'($urandom_range(0, 19));
        bus.fill_w   = 7'($urandom_range(0, 8));
        bus.fill_h   = 5'($urandom_range(0, 4));
      end
      bus.fill_char = 8'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
